boa_csr_mfile: RTL and testbench
================================

// Module: boa_csr_mfile
// PURPOSE
//  Machine-mode CSR register file; the CSR-side endpoint of the CSR access bus and the CSR exception event bus.
//  - Decodes CSR reads/writes issued by the pipeline.
//  - Saves trap state (mepc/mcause/mstatus) on traps and interrupts; restores it on return.
//  - Supplies the trap vector and return address to the pipeline.
// PARAMETERS
//  HARTID      0             value of mhartid (0xF14)
//  RESET_TVEC  32'h0000_0000 mtvec reset value; bit0=1 selects vectored mode
// PORTS
//  clk        in   1   core clock
//  rst        in   1   asynchronous reset, active-high
//  csr_we     in   1   CSR access strobe; write performed only if wmode!=00
//  csr_addr   in   12  CSR address
//  csr_wmode  in   2   00 read-only, 01 write, 10 set bits, 11 clear bits
//  csr_wmask  in   32  rs1/immediate operand
//  csr_exists out  1   addressed CSR is implemented
//  csr_rdonly out  1   csr_addr[11:10]==2'b11
//  csr_priv   out  2   csr_addr[9:8]
//  csr_rdata  out  32  read data; 0 when !csr_exists
//  ex_trap    in   1   synchronous trap this cycle
//  ex_irq     in   1   asynchronous interrupt taken this cycle
//  ex_epc     in   31  exception PC [31:1]
//  ex_cause   in   4   exception/interrupt cause code
//  ex_tvec    out  31  trap vector [31:1]
//  ret        in   1   mret this cycle
//  ret_epc    out  31  mepc[31:1]
//  retire     in   1   one instruction retired this cycle
//  irq_lines  in   3   {MEI,MTI,MSI} raw interrupt levels
//  irq_pend   out  1   |(mip & mie) & mstatus.MIE
// BEHAVIOUR
//  - Reads combinational, latency 0. Writes and trap/ret updates take effect on the next rising clk edge.
//  - Write data = wmask / rdata|wmask / rdata&~wmask by wmode, computed via boa_csrw_helper.
//  - Implemented CSRs:
//    - mstatus 300: MIE b3, MPIE b7 writable; MPP[12:11] hardwired 11.
//    - misa 301: RO 0x4000_0100.
//    - mie 304: b3/b7/b11 writable.
//    - mtvec 305: [31:2] and b0 writable.
//    - mscratch 340, mepc 341 (b0 reads 0), mcause 342: full width writable.
//    - mip 344: RO {MEI b11, MTI b7, MSI b3}.
//    - F11-F13: RO 0. F14: RO HARTID.
//  - Writes to read-only or unimplemented addresses are silently dropped; the pipeline raises the illegal instruction trap.
//  - Trap (ex_trap|ex_irq) on an edge: mepc<=ex_epc; mcause<={ex_irq,27'b0,ex_cause}; MPIE<=MIE; MIE<=0.
//  - ret on an edge: MIE<=MPIE; MPIE<=1.
//  - ex_tvec = mtvec[31:2]<<1, plus ex_cause<<1 when ex_irq && mtvec[0] (vectored). Combinational.
//  - Priority: trap > ret > CSR write.
//    - Trap and ret in the same cycle: ret ignored.
//    - csr_we concurrent with trap or ret: the write is dropped entirely.
//  - Reset (async, any time): mstatus=0x1800, mtvec=RESET_TVEC, all other writable CSRs and counters=0.
//  - All outputs are combinational from state; after reset: ex_tvec=RESET_TVEC[31:1], ret_epc=0, irq_pend=0.
// CONFIGURATION
//  BOA_CSR_COUNTERS_EN defined:
//    - mcycle B00/B80(h) and minstret B02/B82(h) are implemented, with RO aliases C00/C80 and C02/C82.
//    - mcycle increments every cycle; minstret increments on retire.
//    - A CSR write to a half overrides that counter's increment in that cycle; the other half is held.
//    - Low-half wrap 0xFFFF_FFFF->0 carries into the high half.
//  BOA_CSR_COUNTERS_EN undefined: those addresses give csr_exists=0, and no counter flops are synthesised.
// STRUCTURE
//  - Package boa_csr_pkg: CSR address localparams, mstatus bit indices, mcause interrupt bit, misa value.
//  - Sub-module boa_csr_counter64: 64-bit counter with inc, lo/hi write enables, and wdata. Instantiated twice under the macro.
// TESTING
//  - Reset mid-run → mtvec=RESET_TVEC, mstatus=0x1800, mepc=0 read back; irq_pend=0.
//  - Write mscratch=0xDEAD_BEEF, set 0x0000_0011, clear 0xDEAD_0000 → reads 0xDEAD_BEEF, 0xDEAD_BEFF, 0x0000_BEFF.
//  - MIE=1, ex_trap cause 2, epc 0x8000_0104:
//    - next cycle: mepc=0x8000_0104, mcause=2, MIE=0, MPIE=1.
//    - after ret: MIE=1; ret_epc=0x8000_0104.
//  - mtvec=0x0000_0101 with ex_irq cause 7 → ex_tvec*2=0x0000_011C. Same settings with ex_trap → 0x0000_0100.
//  - Same-cycle trap+ret+csr write to mepc → trap state saved, ret ignored, mepc=ex_epc.
//  - Counters, macro defined:
//    - mcycle=0xFFFF_FFFF → next read 0, mcycleh +1.
//    - Write minstret while retire=1 → written value held.
//  - Counters, macro undefined: 0xB00 reads exists=0, rdata=0.

Source files
------------

// File: rtl/boa_csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, field positions,
// constant register values and the read-modify-write data helper.
package boa_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MIMPID    = 12'hF13;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MCAUSE_IRQ   = 31;

    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;
    localparam logic [31:0] MTVEC_MASK   = 32'hFFFF_FFFD;

    typedef enum logic [1:0] {
        WM_READ  = 2'b00,
        WM_WRITE = 2'b01,
        WM_SET   = 2'b10,
        WM_CLEAR = 2'b11
    } csr_wmode_e;

    function automatic logic [31:0] boa_csrw_helper(input csr_wmode_e mode,
                                                    input logic [31:0] rdata,
                                                    input logic [31:0] wmask);
        logic [31:0] res;
        case (mode)
            WM_WRITE: res = wmask;
            WM_SET:   res = rdata | wmask;
            WM_CLEAR: res = rdata & ~wmask;
            default:  res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/boa_csr_counter64.sv
// 64-bit free-running counter with independently writable 32-bit halves.
// Any write suppresses that cycle's increment; the unwritten half is held.
module boa_csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        we_lo_i,
    input  logic        we_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (we_lo_i) count_d[31:0] = wdata_i;
        if (we_hi_i) count_d[63:32] = wdata_i;
        if (inc_i && !we_lo_i && !we_hi_i) count_d = count_q + 64'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/boa_csr_mfile.sv
// Machine-mode CSR register file with trap entry/return state handling.
// Define BOA_CSR_COUNTERS_EN to implement the mcycle/minstret counters and their aliases.
module boa_csr_mfile
    import boa_csr_pkg::*;
#(
    parameter logic [31:0] HARTID     = 32'd0,
    parameter logic [31:0] RESET_TVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_wmode,
    input  logic [31:0] csr_wmask,
    output logic        csr_exists,
    output logic        csr_rdonly,
    output logic [1:0]  csr_priv,
    output logic [31:0] csr_rdata,
    input  logic        ex_trap,
    input  logic        ex_irq,
    input  logic [30:0] ex_epc,
    input  logic [3:0]  ex_cause,
    output logic [30:0] ex_tvec,
    input  logic        ret,
    output logic [30:0] ret_epc,
    input  logic        retire,
    input  logic [2:0]  irq_lines,
    output logic        irq_pend
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [2:0]  irq_en_q, irq_en_d;     // {MEIE, MTIE, MSIE}
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [30:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;

    logic        trap, wr_ok;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exists;

    assign trap  = ex_trap | ex_irq;
    // Trap or return owns the cycle; a concurrent CSR write is discarded.
    assign wr_ok = csr_we && (csr_wmode != 2'b00) && !trap && !ret;
    assign wdata = boa_csrw_helper(csr_wmode_e'(csr_wmode), rdata, csr_wmask);

`ifdef BOA_CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    boa_csr_counter64 u_mcycle (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (1'b1),
        .we_lo_i (wr_ok && csr_addr == CSR_MCYCLE),
        .we_hi_i (wr_ok && csr_addr == CSR_MCYCLEH),
        .wdata_i (wdata),
        .count_o (mcycle)
    );

    boa_csr_counter64 u_minstret (
        .clk_i   (clk),
        .rst_i   (rst),
        .inc_i   (retire),
        .we_lo_i (wr_ok && csr_addr == CSR_MINSTRET),
        .we_hi_i (wr_ok && csr_addr == CSR_MINSTRETH),
        .wdata_i (wdata),
        .count_o (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

    always_comb begin
        exists = 1'b1;
        rdata  = '0;
        case (csr_addr)
            CSR_MSTATUS:  rdata = MSTATUS_MPP | ({31'd0, mpie_q} << MSTATUS_MPIE)
                                              | ({31'd0, mie_q} << MSTATUS_MIE);
            CSR_MISA:     rdata = MISA_VALUE;
            CSR_MIE:      rdata = {20'd0, irq_en_q[2], 3'd0, irq_en_q[1], 3'd0, irq_en_q[0], 3'd0};
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = {mepc_q, 1'b0};
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MIP:      rdata = {20'd0, irq_lines[2], 3'd0, irq_lines[1], 3'd0, irq_lines[0], 3'd0};
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rdata = '0;
            CSR_MHARTID:  rdata = HARTID;
`ifdef BOA_CSR_COUNTERS_EN
            CSR_MCYCLE,    CSR_CYCLE:    rdata = mcycle[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   rdata = mcycle[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  rdata = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
`endif
            default:      exists = 1'b0;
        endcase
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        irq_en_d   = irq_en_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap) begin
            mepc_d   = ex_epc;
            mcause_d = {ex_irq, 27'd0, ex_cause};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (ret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (wr_ok) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mie_d  = wdata[MSTATUS_MIE];
                    mpie_d = wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      irq_en_d   = {wdata[11], wdata[7], wdata[3]};
                CSR_MTVEC:    mtvec_d    = wdata & MTVEC_MASK;
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = wdata[31:1];
                CSR_MCAUSE:   mcause_d   = wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            irq_en_q   <= '0;
            mtvec_q    <= RESET_TVEC & MTVEC_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            irq_en_q   <= irq_en_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    assign csr_exists = exists;
    assign csr_rdata  = rdata;
    assign csr_rdonly = (csr_addr[11:10] == 2'b11);
    assign csr_priv   = csr_addr[9:8];
    // Vectored mode offsets interrupts by 4*cause bytes, i.e. cause<<1 in halfword units.
    assign ex_tvec    = {mtvec_q[31:2], 1'b0}
                      + ((ex_irq && mtvec_q[0]) ? {26'd0, ex_cause, 1'b0} : 31'd0);
    assign ret_epc    = mepc_q;
    assign irq_pend   = (|(irq_lines & irq_en_q)) & mie_q;

endmodule

// File: tb/tb_boa_csr_mfile.sv
// Directed bench for boa_csr_mfile; counter checks follow BOA_CSR_COUNTERS_EN.
module tb_boa_csr_mfile;

    localparam logic [31:0] T_HARTID = 32'h0000_0005;
    localparam logic [31:0] T_TVEC   = 32'h0000_0200;

    localparam logic [2:0] S_RDATA  = 3'd0;
    localparam logic [2:0] S_EXISTS = 3'd1;
    localparam logic [2:0] S_TVEC   = 3'd2;
    localparam logic [2:0] S_REPC   = 3'd3;
    localparam logic [2:0] S_PEND   = 3'd4;
    localparam logic [2:0] S_RPRIV  = 3'd5;

    logic        clk, rst;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [1:0]  csr_wmode;
    logic [31:0] csr_wmask;
    logic        csr_exists, csr_rdonly;
    logic [1:0]  csr_priv;
    logic [31:0] csr_rdata;
    logic        ex_trap, ex_irq;
    logic [30:0] ex_epc;
    logic [3:0]  ex_cause;
    logic [30:0] ex_tvec;
    logic        ret;
    logic [30:0] ret_epc;
    logic        retire;
    logic [2:0]  irq_lines;
    logic        irq_pend;

    boa_csr_mfile #(.HARTID(T_HARTID), .RESET_TVEC(T_TVEC)) dut (
        .clk        (clk),
        .rst        (rst),
        .csr_we     (csr_we),
        .csr_addr   (csr_addr),
        .csr_wmode  (csr_wmode),
        .csr_wmask  (csr_wmask),
        .csr_exists (csr_exists),
        .csr_rdonly (csr_rdonly),
        .csr_priv   (csr_priv),
        .csr_rdata  (csr_rdata),
        .ex_trap    (ex_trap),
        .ex_irq     (ex_irq),
        .ex_epc     (ex_epc),
        .ex_cause   (ex_cause),
        .ex_tvec    (ex_tvec),
        .ret        (ret),
        .ret_epc    (ret_epc),
        .retire     (retire),
        .irq_lines  (irq_lines),
        .irq_pend   (irq_pend)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    logic [31:0] exp_q[$];
    logic [2:0]  sel_q[$];
    string       name_q[$];
    logic        sample_req;
    int          n_vec  = 0;
    int          n_miss = 0;

    logic [31:0] mon_act, mon_exp;
    logic [2:0]  mon_sel;
    string       mon_name;

    always @(negedge clk) begin
        if (sample_req) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL scoreboard_underflow: sample with empty expected queue");
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_sel  = sel_q.pop_front();
                mon_name = name_q.pop_front();
                case (mon_sel)
                    S_RDATA:  mon_act = csr_rdata;
                    S_EXISTS: mon_act = {31'd0, csr_exists};
                    S_TVEC:   mon_act = {ex_tvec, 1'b0};
                    S_REPC:   mon_act = {ret_epc, 1'b0};
                    S_PEND:   mon_act = {31'd0, irq_pend};
                    default:  mon_act = {29'd0, csr_rdonly, csr_priv};
                endcase
                n_vec++;
                if (mon_act !== mon_exp) begin
                    n_miss++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", mon_name, mon_act, mon_exp);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wmode = m;
        csr_wmask = d;
        tick();
        csr_we    = 1'b0;
        csr_wmode = 2'b00;
    endtask

    task automatic expect_obs(input logic [2:0] sel, input logic [11:0] a,
                              input logic [31:0] e, input string nm);
        csr_addr = a;
        exp_q.push_back(e);
        sel_q.push_back(sel);
        name_q.push_back(nm);
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
    endtask

    task automatic trap_pulse(input logic irq, input logic [3:0] cause, input logic [30:0] epc);
        ex_trap  = !irq;
        ex_irq   = irq;
        ex_cause = cause;
        ex_epc   = epc;
        tick();
        ex_trap  = 1'b0;
        ex_irq   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sample_req = 1'b0;
        csr_we = 1'b0; csr_addr = '0; csr_wmode = '0; csr_wmask = '0;
        ex_trap = 1'b0; ex_irq = 1'b0; ex_epc = '0; ex_cause = '0;
        ret = 1'b0; retire = 1'b0; irq_lines = '0;
        #12 rst = 1'b0;
        tick();

        // reset state
        expect_obs(S_RDATA,  12'h300, 32'h0000_1800, "rst_mstatus");
        expect_obs(S_RDATA,  12'h305, T_TVEC,        "rst_mtvec");
        expect_obs(S_RDATA,  12'h341, 32'h0,         "rst_mepc");
        expect_obs(S_PEND,   12'h300, 32'h0,         "rst_irq_pend");
        expect_obs(S_TVEC,   12'h300, T_TVEC,        "rst_ex_tvec");
        expect_obs(S_REPC,   12'h300, 32'h0,         "rst_ret_epc");
        expect_obs(S_RDATA,  12'h301, 32'h4000_0100, "misa");
        expect_obs(S_RDATA,  12'hF14, T_HARTID,      "mhartid");
        expect_obs(S_EXISTS, 12'hF11, 32'h1,         "mvendorid_exists");
        expect_obs(S_RPRIV,  12'hF14, 32'h7,         "rdonly_priv_f14");
        expect_obs(S_RPRIV,  12'h300, 32'h3,         "rdonly_priv_300");
        expect_obs(S_EXISTS, 12'h7C0, 32'h0,         "unimpl_exists");
        expect_obs(S_RDATA,  12'h7C0, 32'h0,         "unimpl_rdata");

        // write / set / clear
        csr_write(12'h340, 2'b01, 32'hDEAD_BEEF);
        expect_obs(S_RDATA, 12'h340, 32'hDEAD_BEEF, "mscratch_write");
        csr_write(12'h340, 2'b10, 32'h0000_0011);
        expect_obs(S_RDATA, 12'h340, 32'hDEAD_BEFF, "mscratch_set");
        csr_write(12'h340, 2'b11, 32'hDEAD_0000);
        expect_obs(S_RDATA, 12'h340, 32'h0000_BEFF, "mscratch_clear");
        csr_write(12'h301, 2'b01, 32'h0);
        expect_obs(S_RDATA, 12'h301, 32'h4000_0100, "misa_write_dropped");

        // trap entry and return
        csr_write(12'h300, 2'b01, 32'h0000_0008);
        expect_obs(S_RDATA, 12'h300, 32'h0000_1808, "mstatus_mie_set");
        trap_pulse(1'b0, 4'd2, 31'h4000_0082);
        expect_obs(S_RDATA, 12'h341, 32'h8000_0104, "trap_mepc");
        expect_obs(S_RDATA, 12'h342, 32'h0000_0002, "trap_mcause");
        expect_obs(S_RDATA, 12'h300, 32'h0000_1880, "trap_mstatus");
        ret = 1'b1;
        tick();
        ret = 1'b0;
        expect_obs(S_RDATA, 12'h300, 32'h0000_1888, "ret_mstatus");
        expect_obs(S_REPC,  12'h300, 32'h8000_0104, "ret_epc");

        csr_write(12'h341, 2'b01, 32'h1234_5679);
        expect_obs(S_RDATA, 12'h341, 32'h1234_5678, "mepc_bit0");
        csr_write(12'h305, 2'b01, 32'hFFFF_FFFF);
        expect_obs(S_RDATA, 12'h305, 32'hFFFF_FFFD, "mtvec_mask");
        csr_write(12'h305, 2'b01, 32'h0000_0101);
        expect_obs(S_RDATA, 12'h305, 32'h0000_0101, "mtvec_vectored");

        // trap vector: vectored interrupt vs synchronous trap
        ex_irq = 1'b1; ex_cause = 4'd7; ex_epc = 31'h0000_0010;
        expect_obs(S_TVEC, 12'h300, 32'h0000_011C, "tvec_irq_vectored");
        ex_irq = 1'b0;
        expect_obs(S_RDATA, 12'h342, 32'h8000_0007, "irq_mcause");
        expect_obs(S_RDATA, 12'h341, 32'h0000_0020, "irq_mepc");
        ex_trap = 1'b1;
        expect_obs(S_TVEC, 12'h300, 32'h0000_0100, "tvec_trap_base");
        ex_trap = 1'b0;
        expect_obs(S_RDATA, 12'h342, 32'h0000_0007, "trap7_mcause");

        // trap + ret + csr write in one cycle
        csr_write(12'h300, 2'b01, 32'h0000_0088);
        expect_obs(S_RDATA, 12'h300, 32'h0000_1888, "mstatus_both_set");
        ex_trap = 1'b1; ex_cause = 4'd3; ex_epc = 31'h0000_0100; ret = 1'b1;
        csr_write(12'h341, 2'b01, 32'h1234_5678);
        ex_trap = 1'b0; ret = 1'b0;
        expect_obs(S_RDATA, 12'h341, 32'h0000_0200, "prio_mepc");
        expect_obs(S_RDATA, 12'h342, 32'h0000_0003, "prio_mcause");
        expect_obs(S_RDATA, 12'h300, 32'h0000_1880, "prio_mstatus");

        // interrupt pending
        csr_write(12'h304, 2'b01, 32'hFFFF_FFFF);
        expect_obs(S_RDATA, 12'h304, 32'h0000_0888, "mie_mask");
        irq_lines = 3'b010;
        expect_obs(S_RDATA, 12'h344, 32'h0000_0080, "mip_mti");
        expect_obs(S_PEND,  12'h300, 32'h0,         "pend_gated_by_mie");
        csr_write(12'h300, 2'b10, 32'h0000_0008);
        expect_obs(S_PEND,  12'h300, 32'h1,         "pend_enabled");
        csr_write(12'h304, 2'b11, 32'h0000_0080);
        expect_obs(S_RDATA, 12'h304, 32'h0000_0808, "mie_clear_mtie");
        expect_obs(S_PEND,  12'h300, 32'h0,         "pend_masked");
        csr_write(12'h344, 2'b01, 32'h0);
        expect_obs(S_RDATA, 12'h344, 32'h0000_0080, "mip_write_dropped");

        // asynchronous reset mid-cycle
        #3 rst = 1'b1;
        #4 rst = 1'b0;
        tick();
        expect_obs(S_RDATA, 12'h305, T_TVEC,        "mid_rst_mtvec");
        expect_obs(S_RDATA, 12'h300, 32'h0000_1800, "mid_rst_mstatus");
        expect_obs(S_RDATA, 12'h341, 32'h0,         "mid_rst_mepc");
        expect_obs(S_RDATA, 12'h340, 32'h0,         "mid_rst_mscratch");
        expect_obs(S_PEND,  12'h300, 32'h0,         "mid_rst_irq_pend");
        irq_lines = 3'b000;

`ifdef BOA_CSR_COUNTERS_EN
        csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
        expect_obs(S_RDATA, 12'hB00, 32'hFFFF_FFFF, "mcycle_written");
        expect_obs(S_RDATA, 12'hB00, 32'h0,         "mcycle_wrap");
        expect_obs(S_RDATA, 12'hB80, 32'h1,         "mcycleh_carry");
        expect_obs(S_RDATA, 12'hC80, 32'h1,         "cycleh_alias");
        retire = 1'b1;
        csr_write(12'hB02, 2'b01, 32'h0000_0055);
        retire = 1'b0;
        expect_obs(S_RDATA, 12'hB02, 32'h0000_0055, "minstret_write_wins");
        retire = 1'b1;
        tick();
        retire = 1'b0;
        expect_obs(S_RDATA, 12'hC02, 32'h0000_0056, "instret_alias_inc");
        expect_obs(S_RDATA, 12'hB82, 32'h0,         "minstreth_held");
`else
        expect_obs(S_EXISTS, 12'hB00, 32'h0, "mcycle_absent");
        expect_obs(S_RDATA,  12'hB00, 32'h0, "mcycle_rdata_zero");
        expect_obs(S_EXISTS, 12'hC02, 32'h0, "instret_absent");
`endif

        tick();
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
